// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: SPI mode-0 slave that fills and dumps a DFF byte memory.
// Pins are oversampled in the clk domain; memory strobes are 1-cycle pulses.
module spi_mem_ctrl #(
    parameter int  RAM_BYTES   = 16,
    parameter int  SYNC_STAGES = 2,
    localparam int ADDR_BITS   = $clog2(RAM_BYTES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_lr_n,
    output logic                 mem_ce_n,
    input  logic [7:0]           mem_rdata,
    output logic                 busy
);

    localparam int FW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
    logic [FW-1:0]          fill;
    logic                   armed;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift, tx_shift;
    logic                   inc, oor, wr_q, rd_q, skip_fall;

    logic                 sclk_rise, sclk_fall, cs_sync, mosi_sync;
    logic                 sync_full, active, byte_done, field_oor;
    logic [7:0]           rx_byte;
    logic [ADDR_BITS-1:0] addr_field, addr_next;

    // [0] is the newest sample, [SYNC_STAGES-1] the settled one
    assign sclk_rise  = sclk_s[SYNC_STAGES-2] & ~sclk_s[SYNC_STAGES-1];
    assign sclk_fall  = ~sclk_s[SYNC_STAGES-2] & sclk_s[SYNC_STAGES-1];
    assign cs_sync    = cs_s[SYNC_STAGES-1];
    assign mosi_sync  = mosi_s[SYNC_STAGES-1];
    assign sync_full  = (int'(fill) == SYNC_STAGES);
    assign active     = (state != IDLE) && !cs_sync;
    assign byte_done  = active && sclk_rise && (bit_cnt == 3'd7);
    assign rx_byte    = {rx_shift[6:0], mosi_sync};
    assign addr_field = rx_byte[ADDR_BITS-1:0];
    assign field_oor  = (int'(addr_field) >= RAM_BYTES);
    assign addr_next  = (int'(mem_addr) >= RAM_BYTES - 1) ? '0
                      : mem_addr + ADDR_BITS'(1);

    assign miso_oe = ~cs_sync;
    assign busy    = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state; a deselected host always wins.
    // armed blocks the false cs_n fall seen while the synchronizer refills
    // after reset, so a frame interrupted by reset is never resumed.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (armed && !cs_sync) state_nx = CMD;
            CMD:   if (byte_done) state_nx = rx_byte[7] ? RDATA : WDATA;
            WDATA: state_nx = WDATA;
            RDATA: state_nx = RDATA;
        endcase
        if (cs_sync) state_nx = IDLE;
    end

    // Synchronizers, shifters and memory strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_s    <= '0;
            cs_s      <= '1;
            mosi_s    <= '0;
            fill      <= '0;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            inc       <= 1'b0;
            oor       <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            skip_fall <= 1'b0;
            miso      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_lr_n  <= 1'b1;
            mem_ce_n  <= 1'b1;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
            cs_s   <= {cs_s[SYNC_STAGES-2:0], cs_n};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
            if (!sync_full) fill <= fill + FW'(1);
            if (sync_full && cs_sync) armed <= 1'b1;
            mem_lr_n <= 1'b1;
            mem_ce_n <= 1'b1;
            if (state_nx == IDLE) begin
                bit_cnt   <= '0;
                rx_shift  <= '0;
                tx_shift  <= '0;
                wr_q      <= 1'b0;
                rd_q      <= 1'b0;
                skip_fall <= 1'b0;
                miso      <= 1'b0;
            end else begin
                if (active && sclk_rise) begin
                    rx_shift <= rx_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (state == CMD && byte_done) begin
                    inc      <= rx_byte[6];
                    oor      <= field_oor;
                    mem_addr <= addr_field;
                    if (rx_byte[7]) begin
                        rd_q     <= 1'b1;
                        mem_ce_n <= field_oor;
                    end
                end
                if (state == WDATA && byte_done) begin
                    mem_wdata <= rx_byte;
                    mem_lr_n  <= oor;
                    wr_q      <= 1'b1;
                end
                if (state == RDATA && byte_done) begin
                    rd_q     <= 1'b1;
                    mem_ce_n <= oor;
                end
                if (wr_q) begin
                    wr_q <= 1'b0;
                    if (inc) begin
                        mem_addr <= addr_next;
                        oor      <= 1'b0;
                    end
                end
                if (rd_q) begin
                    rd_q      <= 1'b0;
                    tx_shift  <= oor ? 8'h00 : mem_rdata;
                    miso      <= oor ? 1'b0 : mem_rdata[7];
                    skip_fall <= 1'b1;
                    if (inc) begin
                        mem_addr <= addr_next;
                        oor      <= 1'b0;
                    end
                end else if (state == RDATA && sclk_fall) begin
                    if (skip_fall) begin
                        skip_fall <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        miso     <= tx_shift[6];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: drives SPI frames into spi_mem_ctrl backed by a byte
// memory, checking vectors and random frames against a frame-level model.
module tb_spi_mem_ctrl;

    localparam int RAM  = 16;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, mosi;
    logic       miso, miso_oe, mem_lr_n, mem_ce_n, busy;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] mem [RAM];
    logic [7:0] ref_mem [RAM];
    logic       pre_we;
    logic [3:0] pre_a;
    logic [7:0] pre_d;

    int tests = 0;
    int fails = 0;
    int lr_cnt = 0, ce_cnt = 0, overlap_err = 0, width_err = 0;
    logic lr_prev = 1'b0, ce_prev = 1'b0;
    logic [11:0] wlog [$];

    spi_mem_ctrl #(.RAM_BYTES(RAM), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_lr_n(mem_lr_n), .mem_ce_n(mem_ce_n),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Byte memory: write on the edge where mem_lr_n is low
    always @(posedge clk) begin
        if (!mem_lr_n) mem[mem_addr] <= mem_wdata;
        else if (pre_we) mem[pre_a] <= pre_d;
    end

    assign mem_rdata = mem_ce_n ? 8'hEE : mem[mem_addr];

    // Strobe monitor
    always @(negedge clk) begin
        if (!mem_lr_n) begin
            lr_cnt++;
            wlog.push_back({mem_addr, mem_wdata});
        end
        if (!mem_ce_n) ce_cnt++;
        if (!mem_lr_n && !mem_ce_n) overlap_err++;
        if ((!mem_lr_n && lr_prev) || (!mem_ce_n && ce_prev)) width_err++;
        lr_prev = !mem_lr_n;
        ce_prev = !mem_ce_n;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: timeout expired, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]       cmd;
        int               n;
        logic [3:0][7:0]  d;
        int               xb;
        int               exp_lr;
        int               exp_ce;
        logic [3:0][7:0]  exp_rx;
        logic [3:0][3:0]  exp_wa;
        logic [3:0]       exp_addr;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t mk(input logic [7:0] cmd, input int n,
        input logic [7:0] d0, input logic [7:0] d1, input int xb,
        input int lr, input int ce, input logic [7:0] r0,
        input logic [7:0] r1, input logic [7:0] r2, input logic [3:0] wa0,
        input logic [3:0] wa1, input logic [3:0] fa);
        vec_t v;
        v.cmd = cmd; v.n = n; v.d = {8'h00, 8'h00, d1, d0}; v.xb = xb;
        v.exp_lr = lr; v.exp_ce = ce; v.exp_rx = {8'h00, r2, r1, r0};
        v.exp_wa = {4'h0, 4'h0, wa1, wa0}; v.exp_addr = fa;
        return v;
    endfunction

    // Host side: shift nbits MSB-first, sample miso just before each rise
    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int n,
        input logic [3:0][7:0] d, input int xb, input logic [7:0] xv,
        output logic [3:0][7:0] rx);
        logic [7:0] r;
        rx = '0;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(cmd, 8, r);
        check("busy_in_frame", busy, 1);
        check("oe_in_frame", miso_oe, 1);
        for (int i = 0; i < n; i++) begin
            spi_bits(d[i], 8, r);
            rx[i] = r;
        end
        if (xb > 0) spi_bits(xv, xb, r);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("busy_after_cs", busy, 0);
        check("oe_after_cs", miso_oe, 0);
        check("miso_after_cs", miso, 0);
    endtask

    // Frame-level model: addresses step through memory as bytes complete
    task automatic model_frame(input logic [7:0] cmd, input int n,
        input logic [3:0][7:0] d, output int lr, output int ce,
        output logic [3:0][7:0] rx, output logic [3:0] fa);
        int a;
        a = int'(cmd[3:0]);
        rx = '0;
        lr = 0;
        ce = 0;
        if (cmd[7]) begin
            ce = n + 1;
            for (int i = 0; i <= n; i++) begin
                if (i < n) rx[i] = ref_mem[a];
                if (cmd[6]) a = (a + 1) % RAM;
            end
        end else begin
            lr = n;
            for (int i = 0; i < n; i++) begin
                ref_mem[a] = d[i];
                if (cmd[6]) a = (a + 1) % RAM;
            end
        end
        fa = 4'(a);
    endtask

    initial begin
        logic [3:0][7:0] rx, mrx, d;
        logic [7:0]      r, v8;
        logic [3:0]      mfa;
        int lr0, ce0, w0, mlr, mce, n, xb;
        logic [7:0] cmd;

        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;

        // preload memory while in reset
        for (int i = 0; i < RAM; i++) begin
            @(negedge clk);
            case (i)
                0:  v8 = 8'h7E;
                2:  v8 = 8'h3C;
                15: v8 = 8'h81;
                default: v8 = 8'(i * 17);
            endcase
            ref_mem[i] = v8;
            pre_we = 1'b1; pre_a = 4'(i); pre_d = v8;
        end
        @(negedge clk);
        pre_we = 1'b0;

        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_lr_n", mem_lr_n, 1);
        check("rst_mem_ce_n", mem_ce_n, 1);
        check("rst_busy", busy, 0);

        rst_n = 1'b1;
        lr0 = lr_cnt; ce0 = ce_cnt;
        repeat (20) @(negedge clk);
        check("idle_no_lr", lr_cnt - lr0, 0);
        check("idle_no_ce", ce_cnt - ce0, 0);
        check("idle_busy", busy, 0);

        //         cmd    n  d0     d1     xb lr ce r0     r1     r2     wa0 wa1 fa
        vt.push_back(mk(8'h43, 2, 8'hA5, 8'h5A, 0, 2, 0, 8'h00, 8'h00, 8'h00, 3, 4, 5));
        vt.push_back(mk(8'hCF, 2, 8'h00, 8'h00, 0, 0, 3, 8'h81, 8'h7E, 8'h00, 0, 0, 2));
        vt.push_back(mk(8'h82, 3, 8'hFF, 8'h00, 0, 0, 4, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2));
        vt.push_back(mk(8'hC3, 2, 8'h00, 8'h00, 0, 0, 3, 8'hA5, 8'h5A, 8'h00, 0, 0, 6));
        vt.push_back(mk(8'h41, 0, 8'h00, 8'h00, 5, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1));
        vt.push_back(mk(8'h81, 1, 8'h00, 8'h00, 0, 0, 2, 8'h11, 8'h00, 8'h00, 0, 0, 1));
        vt.push_back(mk(8'h01, 2, 8'h22, 8'h33, 0, 2, 0, 8'h00, 8'h00, 8'h00, 1, 1, 1));
        vt.push_back(mk(8'h81, 1, 8'h00, 8'h00, 0, 0, 2, 8'h33, 8'h00, 8'h00, 0, 0, 1));
        vt.push_back(mk(8'h4F, 2, 8'hC1, 8'hC2, 0, 2, 0, 8'h00, 8'h00, 8'h00, 15, 0, 1));
        vt.push_back(mk(8'hCF, 2, 8'h00, 8'h00, 0, 0, 3, 8'hC1, 8'hC2, 8'h00, 0, 0, 2));

        foreach (vt[k]) begin
            model_frame(vt[k].cmd, vt[k].n, vt[k].d, mlr, mce, mrx, mfa);
            lr0 = lr_cnt; ce0 = ce_cnt; w0 = wlog.size();
            run_frame(vt[k].cmd, vt[k].n, vt[k].d, vt[k].xb, 8'hFF, rx);
            check($sformatf("v%0d_lr", k), lr_cnt - lr0, vt[k].exp_lr);
            check($sformatf("v%0d_ce", k), ce_cnt - ce0, vt[k].exp_ce);
            check($sformatf("v%0d_addr", k), mem_addr, vt[k].exp_addr);
            for (int i = 0; i < vt[k].n; i++) begin
                if (vt[k].cmd[7]) begin
                    check($sformatf("v%0d_rx%0d", k, i), rx[i], vt[k].exp_rx[i]);
                end else if (wlog.size() > w0 + i) begin
                    check($sformatf("v%0d_wr%0d", k, i), wlog[w0 + i],
                          {vt[k].exp_wa[i], vt[k].d[i]});
                end
            end
        end

        // reset in the middle of a write data byte
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h45, 8, r);
        spi_bits(8'hFF, 4, r);
        lr0 = lr_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_lr_n", mem_lr_n, 1);
        check("mid_rst_ce_n", mem_ce_n, 1);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_oe", miso_oe, 0);
        rst_n = 1'b1;
        spi_bits(8'hFF, 4, r);
        repeat (20) @(negedge clk);
        check("mid_rst_no_resume", busy, 0);
        check("mid_rst_no_write", lr_cnt - lr0, 0);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        d = {8'h00, 8'h00, 8'h00, 8'h99};
        model_frame(8'h45, 1, d, mlr, mce, mrx, mfa);
        run_frame(8'h45, 1, d, 0, 8'h00, rx);
        d = '0;
        model_frame(8'h85, 1, d, mlr, mce, mrx, mfa);
        run_frame(8'h85, 1, d, 0, 8'h00, rx);
        check("post_rst_readback", rx[0], 8'h99);

        // random frames against the model
        for (int t = 0; t < 40; t++) begin
            cmd = 8'($urandom);
            n = $urandom_range(0, 3);
            xb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            d = {$urandom, $urandom} ;
            model_frame(cmd, n, d, mlr, mce, mrx, mfa);
            lr0 = lr_cnt; ce0 = ce_cnt;
            run_frame(cmd, n, d, xb, 8'($urandom), rx);
            check($sformatf("rnd%0d_lr", t), lr_cnt - lr0, mlr);
            check($sformatf("rnd%0d_ce", t), ce_cnt - ce0, mce);
            check($sformatf("rnd%0d_addr", t), mem_addr, mfa);
            if (cmd[7]) begin
                for (int i = 0; i < n; i++)
                    check($sformatf("rnd%0d_rx%0d", t, i), rx[i], mrx[i]);
            end
        end

        for (int i = 0; i < RAM; i++)
            check($sformatf("mem%0d", i), mem[i], ref_mem[i]);
        check("strobe_overlap", overlap_err, 0);
        check("strobe_width", width_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
- SPI-slave front end (mode 0, MSB first) that sits directly upstream of the DFF byte memory and drives its address, load and chip-enable controls.
- Lets an external host fill and dump the memory over 4 pins instead of a parallel bus.
- SPI pins are asynchronous to clk; they are oversampled and edge-detected inside the clk domain.

Parameters:
- RAM_BYTES, 16, memory depth in bytes. ADDR_BITS = $clog2(RAM_BYTES) is derived locally.
- SYNC_STAGES, 2, flop count of the input synchronizers on sclk, cs_n and mosi; minimum 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- sclk  in  1  SPI clock from host, asynchronous.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data from host, asynchronous.
- miso  out  1  SPI data to host.
- miso_oe  out  1  high while the frame is selected (synchronized cs_n low).
- mem_addr  out  ADDR_BITS  memory address.
- mem_wdata  out  8  write data to memory.
- mem_lr_n  out  1  active-low load strobe; memory writes on the clk edge where it is low.
- mem_ce_n  out  1  active-low read enable.
- mem_rdata  in  8  memory read data; combinationally valid while mem_ce_n is low.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low at posedge clk) values:
  - miso=0, miso_oe=0, mem_addr=0, mem_wdata=0, mem_lr_n=1, mem_ce_n=1, busy=0.
  - Synchronizer flops set to sclk=0, cs_n=1, mosi=0.
  - FSM=IDLE; bit counter, shift registers and flags cleared.
- Edge detection:
  - Rise and fall of sclk are detected from the last two synchronizer stages.
  - Host sclk high and low times must each be at least SYNC_STAGES+2 clk cycles.
- FSM states are IDLE, CMD, WDATA and RDATA.
  - IDLE -> CMD when synced cs_n falls; bit counter cleared.
  - Any state -> IDLE when synced cs_n is high. A partially shifted byte is discarded with no memory access. mem_lr_n and mem_ce_n return to 1 the same cycle.
- Bit capture:
  - On each sclk rise, mosi is shifted into rx_shift[0] and the bit counter increments mod 8.
  - Byte complete = the 8th rise.
- Command byte (CMD state):
  - bit7 R/W: 1 = read, 0 = write.
  - bit6 INC: 1 = auto-increment address after each data byte.
  - bits[ADDR_BITS-1:0] = start address; other bits are ignored.
  - On byte complete: mem_addr <= address field; FSM -> RDATA if R/W=1, else -> WDATA.
- WDATA state, on byte complete:
  - Next clk: mem_wdata <= rx byte and mem_lr_n=0 for exactly 1 cycle.
  - The clk after that: if INC=1, mem_addr increments, wrapping RAM_BYTES-1 -> 0.
- RDATA state, fetch:
  - Trigger: entry from CMD (same cycle as the command byte completes), then every data byte complete.
  - Next clk: mem_ce_n=0 for exactly 1 cycle; tx_shift <= mem_rdata in that cycle; miso <= mem_rdata[7].
  - The clk after that: if INC=1, mem_addr increments with wrap.
  - The first byte returned is therefore mem[start]; mosi data during RDATA is ignored.
- RDATA state, shifting:
  - On each sclk fall, tx_shift shifts left and miso <= new tx_shift[7].
  - Exception: the first fall after a fetch is skipped (flag), so bit7 stays valid for the host's next rise.
- Out-of-range start address (field >= RAM_BYTES, non-power-of-2 depth):
  - Writes are suppressed (no mem_lr_n pulse).
  - Reads return 0x00 with mem_ce_n held high.
  - Auto-increment wraps to 0 and access resumes normally.
- Status outputs:
  - miso outside RDATA is 0.
  - miso_oe = synced cs_n low.
  - busy = (FSM != IDLE).
- Reset mid-frame: immediate return to reset values; the frame is not resumed even if cs_n stays low. The next frame requires a cs_n fall.
- mem_lr_n and mem_ce_n are never low in the same cycle.

Test Plan:
- Reset with cs_n=1 -> all outputs at reset values; no mem_lr_n or mem_ce_n pulse for 20 cycles.
- Write frame: cmd 0x43 (write, INC, addr 3), data 0xA5, 0x5A -> two 1-cycle mem_lr_n pulses, at mem_addr=3 with mem_wdata=0xA5, then mem_addr=4 with mem_wdata=0x5A; busy drops after cs_n rises.
- Read frame with memory model preloaded mem[15]=0x81, mem[0]=0x7E: cmd 0xCF (read, INC, addr 15), 16 sclk -> host receives 0x81 then 0x7E (wrap-around); one mem_ce_n pulse per byte.
- Non-increment read: cmd 0x82 (read, addr 2), 3 bytes -> mem_addr stays 2 and all bytes equal mem[2].
- Abort: cmd 0x41 then 5 data bits, cs_n high -> no mem_lr_n pulse, FSM IDLE, mem[1] unchanged; next frame works normally.
- rst_n low for 1 cycle during WDATA after 4 bits -> reset values next cycle, no write; a new frame completes correctly.
